// File: rtl/vga_scan_driver.sv
// vga_scan_driver
// Raster timing generator and colour sink for the overlay pixel interface.
// Free-running column/row counters are driven out as pixel coordinates. The
// overlay and map blocks answer with 2-bit codes PIPE_LAT cycles later. The
// blank/sync flags are derived from the same counters and delayed by PIPE_LAT
// stages, so they meet the returning codes in step. A final register stage
// then drives the sync, blanking and RGB outputs.
//
// Ports
//   vga_clock    in   pixel clock, rising edge
//   reset        in   synchronous, active-high
//   icon[1:0]    in   overlay code for the coordinate issued PIPE_LAT cycles ago
//   world_pixel  in   map code for the same coordinate
//   Rowpx[9:0]   out  raw vertical counter (includes blanking rows)
//   Colpx[9:0]   out  raw horizontal counter (includes blanking columns)
//   horiz_sync   out  active-low hsync, aligned with RGB
//   vert_sync    out  active-low vsync, aligned with RGB
//   video_on     out  visible-region flag, aligned with RGB
//   vga_red/green/blue[3:0] out  pixel colour
//   frame_tick   out  one-cycle pulse when the counters return to (0,0)
module vga_scan_driver #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int PIPE_LAT  = 3
) (
   input  logic       vga_clock,
   input  logic       reset,
   input  logic [1:0] icon,
   input  logic [1:0] world_pixel,
   output logic [9:0] Rowpx,
   output logic [9:0] Colpx,
   output logic       horiz_sync,
   output logic       vert_sync,
   output logic       video_on,
   output logic [3:0] vga_red,
   output logic [3:0] vga_green,
   output logic [3:0] vga_blue,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0]          col_q, col_d;
   logic [9:0]          row_q, row_d;
   logic [PIPE_LAT-1:0] vis_dly_q, vis_dly_d;
   logic [PIPE_LAT-1:0] hs_dly_q, hs_dly_d;
   logic [PIPE_LAT-1:0] vs_dly_q, vs_dly_d;
   logic                video_on_q, video_on_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic                frame_tick_q, frame_tick_d;
   logic [11:0]         rgb_q, rgb_d;

   logic line_end;
   logic vis_raw, hs_raw, vs_raw;
   logic vis_late;

   always_comb begin
      line_end = (col_q == H_LAST);

      col_d = line_end ? 10'd0 : col_q + 10'd1;
      row_d = row_q;
      if (line_end) begin
         row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
      end

      // Registered so the pulse lines up with the cycle that shows (0,0).
      frame_tick_d = line_end && (row_q == V_LAST);

      vis_raw = (col_q < H_VIS) && (row_q < V_VIS);
      hs_raw  = !((col_q >= H_SYNC_START) && (col_q < H_SYNC_END));
      vs_raw  = !((row_q >= V_SYNC_START) && (row_q < V_SYNC_END));

      // Bit 0 is the newest entry; bit PIPE_LAT-1 matches the codes on icon/world_pixel.
      vis_dly_d = (vis_dly_q << 1) | PIPE_LAT'(vis_raw);
      hs_dly_d  = (hs_dly_q  << 1) | PIPE_LAT'(hs_raw);
      vs_dly_d  = (vs_dly_q  << 1) | PIPE_LAT'(vs_raw);

      vis_late   = vis_dly_q[PIPE_LAT-1];
      video_on_d = vis_late;
      hsync_d    = hs_dly_q[PIPE_LAT-1];
      vsync_d    = vs_dly_q[PIPE_LAT-1];

      rgb_d = 12'h000;
      if (vis_late) begin
         if (icon != 2'b00) begin
            case (icon)
               2'b01:   rgb_d = 12'hF00;
               2'b10:   rgb_d = 12'h0F0;
               default: rgb_d = 12'hFF0;
            endcase
         end else begin
            case (world_pixel)
               2'b00:   rgb_d = 12'hFFF;
               2'b01:   rgb_d = 12'h000;
               2'b10:   rgb_d = 12'hF80;
               default: rgb_d = 12'h00F;
            endcase
         end
      end
   end

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         vis_dly_q    <= '0;
         hs_dly_q     <= '1;
         vs_dly_q     <= '1;
         video_on_q   <= 1'b0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         frame_tick_q <= 1'b0;
         rgb_q        <= 12'h000;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         vis_dly_q    <= vis_dly_d;
         hs_dly_q     <= hs_dly_d;
         vs_dly_q     <= vs_dly_d;
         video_on_q   <= video_on_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         frame_tick_q <= frame_tick_d;
         rgb_q        <= rgb_d;
      end
   end

   assign Colpx      = col_q;
   assign Rowpx      = row_q;
   assign horiz_sync = hsync_q;
   assign vert_sync  = vsync_q;
   assign video_on   = video_on_q;
   assign frame_tick = frame_tick_q;
   assign {vga_red, vga_green, vga_blue} = rgb_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver. It uses a reduced raster (220 x 72 totals) so that
// several full frames fit in a short run. The expected outputs come from a
// cycle index measured from reset release: the counters and flags are plain
// div/mod arithmetic on that index. The colour is looked up from the codes the
// bench drove one cycle earlier.
module tb_vga_scan_driver;
   localparam int HV = 160, HF = 16, HS = 24, HB = 20;
   localparam int VV = 60,  VF = 4,  VS = 2,  VB = 6;
   localparam int LAT = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic       vga_clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] icon = 2'b00;
   logic [1:0] world_pixel = 2'b00;
   logic [9:0] Rowpx, Colpx;
   logic       horiz_sync, vert_sync, video_on, frame_tick;
   logic [3:0] vga_red, vga_green, vga_blue;

   vga_scan_driver #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_LAT(LAT)
   ) dut (
      .vga_clock(vga_clock), .reset(reset), .icon(icon), .world_pixel(world_pixel),
      .Rowpx(Rowpx), .Colpx(Colpx), .horiz_sync(horiz_sync), .vert_sync(vert_sync),
      .video_on(video_on), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
      .frame_tick(frame_tick)
   );

   always #5 vga_clock = ~vga_clock;

   int         errors = 0;
   int         checks = 0;
   int         n = 0;
   int         ticks = 0;
   bit         checking = 1'b0;
   logic [1:0] prev_icon = 2'b00;
   logic [1:0] prev_world = 2'b00;
   int         pin_rgb[int];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d: got %0h, expected %0h", name, n, got, exp);
      end
   endtask

   function automatic logic [11:0] colour(input logic [1:0] ic, input logic [1:0] wp);
      logic [11:0] icon_lut[4];
      logic [11:0] world_lut[4];
      icon_lut  = '{12'h000, 12'hF00, 12'h0F0, 12'hFF0};
      world_lut = '{12'hFFF, 12'h000, 12'hF80, 12'h00F};
      return (ic != 2'b00) ? icon_lut[ic] : world_lut[wp];
   endfunction

   // ---------------- compare process ----------------
   bit last_hs, last_vs, last_vo;
   bit hs_arm, vs_arm, vo_arm;
   int hs_run, vs_run, vo_run;

   always @(negedge vga_clock) begin
      if (checking) begin
         int          m, c, r;
         logic        e_vis, e_hs, e_vs;
         logic [11:0] e_rgb;

         if (n < LAT + 1) begin
            e_vis = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
         end else begin
            m = n - LAT - 1;
            c = m % HT;
            r = (m / HT) % VT;
            e_vis = (c < HV) && (r < VV);
            e_hs  = !((c >= HV + HF) && (c < HV + HF + HS));
            e_vs  = !((r >= VV + VF) && (r < VV + VF + VS));
            e_rgb = e_vis ? colour(prev_icon, prev_world) : 12'h000;
         end

         check("colpx", 32'(Colpx), n % HT);
         check("rowpx", 32'(Rowpx), (n / HT) % VT);
         check("frame_tick", 32'(frame_tick), (n > 0 && n % FRAME == 0) ? 1 : 0);
         check("video_on", 32'(video_on), 32'(e_vis));
         check("horiz_sync", 32'(horiz_sync), 32'(e_hs));
         check("vert_sync", 32'(vert_sync), 32'(e_vs));
         check("rgb", 32'({vga_red, vga_green, vga_blue}), 32'(e_rgb));
         if (frame_tick) ticks++;

         if (pin_rgb.exists(n)) check("pinned_rgb", 32'({vga_red, vga_green, vga_blue}), pin_rgb[n]);
         if (n <= LAT) begin
            check("post_reset_rgb", 32'({vga_red, vga_green, vga_blue}), 0);
            check("post_reset_hsync", 32'(horiz_sync), 1);
            check("post_reset_vsync", 32'(vert_sync), 1);
            check("post_reset_video_on", 32'(video_on), 0);
         end
         if (n == 4) check("first_video_on", 32'(video_on), 1);

         if (n == 0) begin
            hs_arm = 0; vs_arm = 0; vo_arm = 0;
            hs_run = 0; vs_run = 0; vo_run = 0;
            last_hs = 1; last_vs = 1; last_vo = 0;
         end

         if (last_hs && !horiz_sync) begin
            check("hsync_start", (n - LAT - 1) % HT, HV + HF);
            hs_arm = 1; hs_run = 1;
         end else if (!horiz_sync) hs_run++;
         else if (!last_hs && hs_arm) check("hsync_width", hs_run, HS);

         if (last_vs && !vert_sync) begin
            check("vsync_start", (n - LAT - 1) % FRAME, (VV + VF) * HT);
            vs_arm = 1; vs_run = 1;
         end else if (!vert_sync) vs_run++;
         else if (!last_vs && vs_arm) check("vsync_width", vs_run, VS * HT);

         if (!last_vo && video_on) begin
            vo_arm = 1; vo_run = 1;
         end else if (video_on) vo_run++;
         else if (last_vo && vo_arm) check("video_on_width", vo_run, HV);

         last_hs = horiz_sync;
         last_vs = vert_sync;
         last_vo = video_on;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_inputs();
      int d, c, r;
      icon        = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      world_pixel = 2'($urandom_range(0, 3));
      d = n - LAT;
      if (d >= 0) begin
         c = d % HT;
         r = (d / HT) % VT;
         if (r == 10) begin
            icon = 2'b11;
            if (c >= HV) pin_rgb[n + 1] = 12'h000;
         end
         if (r == 50 && c == 100) begin
            icon = 2'b10; world_pixel = 2'b11; pin_rgb[n + 1] = 12'h0F0;
         end
         if (r == 50 && c == 101) begin
            icon = 2'b00; world_pixel = 2'b10; pin_rgb[n + 1] = 12'hF80;
         end
         if (r == 50 && c == 102) begin
            icon = 2'b00; world_pixel = 2'b00; pin_rgb[n + 1] = 12'hFFF;
         end
      end
   endtask

   task automatic step();
      @(posedge vga_clock);
      #1;
      prev_icon  = icon;
      prev_world = world_pixel;
      n++;
      drive_inputs();
   endtask

   initial begin
      repeat (3) @(posedge vga_clock);
      #1;
      reset = 1'b0;
      n = 0;
      checking = 1'b1;
      drive_inputs();

      // Two full frames, then stop at row 40 / column 100 of the third frame.
      for (int k = 0; k < 2 * FRAME + 40 * HT + 100; k++) step();

      // Assert reset for one cycle in the middle of the frame.
      reset = 1'b1;
      @(posedge vga_clock);
      #1;
      reset = 1'b0;
      pin_rgb.delete();
      prev_icon  = icon;
      prev_world = world_pixel;
      n = 0;
      drive_inputs();

      for (int k = 0; k < FRAME + 1000; k++) step();

      @(negedge vga_clock);
      #1;
      checking = 1'b0;
      check("frame_tick_count", ticks, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Generates 640x480 @ 60 Hz VGA raster timing from `vga_clock`. Drives the pixel coordinates (`Rowpx`, `Colpx`) consumed by the icon overlay and world-map lookup blocks. Takes back their 2-bit pixel codes after a fixed pipeline latency, then produces aligned sync, blanking and 12-bit RGB to the connector. It is the scan source and colour sink of the overlay pixel interface.

## Interface
- `H_VISIBLE`, 640: visible columns
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BACK`, 48: horizontal back porch
- `V_VISIBLE`, 480: visible rows
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BACK`, 33: vertical back porch
- `PIPE_LAT`, 3: cycles from coordinate out to `icon`/`world_pixel` valid in (range 1..8)
- `vga_clock` input 1: pixel clock; all logic on rising edge
- `reset` input 1: one clock; reset is synchronous and active-high
- `icon` input 2: overlay code for coordinate issued `PIPE_LAT` cycles earlier
- `world_pixel` input 2: map code for the same coordinate
- `Rowpx` output 10: current vertical count
- `Colpx` output 10: current horizontal count
- `horiz_sync` output 1: active-low hsync
- `vert_sync` output 1: active-low vsync
- `video_on` output 1: visible-region flag, aligned with RGB
- `vga_red`, `vga_green`, `vga_blue` output 4 each: pixel colour
- `frame_tick` output 1: one-cycle pulse at start of frame

## Operation
- `H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK` (800). `V_TOTAL` is formed the same way (525).
- `Colpx` counts 0..H_TOTAL-1 and wraps to 0.
- `Rowpx` increments only when `Colpx` wraps. It wraps 0..V_TOTAL-1.
- Coordinates are the raw counter registers and include blanking values. Downstream blocks tolerate coordinates ≥ 640/480.
- Raw flags are computed from the counters:
  - vis = `Colpx < H_VISIBLE && Rowpx < V_VISIBLE`
  - hs_n is low for `Colpx` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751).
  - vs_n is low for `Rowpx` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
- The raw flags pass through a delay line of `PIPE_LAT` registers. A final output register follows, so total delay is `PIPE_LAT+1`.
- RGB output register, loaded every cycle from the `PIPE_LAT`-delayed vis:
  - If delayed vis is 0, load 0x000.
  - Otherwise, if `icon != 0`: 01→F00, 10→0F0, 11→FF0. Icon has priority over world.
  - Otherwise by `world_pixel`: 00→FFF, 01→000, 10→F80, 11→00F.
- `frame_tick` is 1 exactly in the cycle where the counters read (0,0) following a wrap from (H_TOTAL-1, V_TOTAL-1). It is not delayed.

## Timing
- Reset (sampled high at an edge) sets:
  - `Colpx` = 0, `Rowpx` = 0
  - every delay-line stage to inactive: vis = 0, hs_n = 1, vs_n = 1
  - `horiz_sync` = 1, `vert_sync` = 1, `video_on` = 0
  - RGB = 0x000, `frame_tick` = 0
- The first cycle after reset shows `Colpx` = 0. It increments by 1 per cycle from then on.
- No `frame_tick` is produced on reset exit. The first tick comes after one full frame (H_TOTAL·V_TOTAL = 420000 cycles).
- Coordinate presented at cycle t:
  - `icon`/`world_pixel` are sampled at t+PIPE_LAT.
  - RGB, `video_on`, `horiz_sync` and `vert_sync` for it appear at t+PIPE_LAT+1.
- All of these outputs stay mutually aligned through every wrap.
- Reset asserted mid-line or mid-frame:
  - Takes effect at the next edge and flushes the delay line.
  - Outputs then show blank/inactive for `PIPE_LAT+1` cycles after release, regardless of `icon`.
- Horizontal wrap and vertical wrap land in the same cycle at the frame end. `Rowpx` returns to 0 exactly when `Colpx` does.
- Icon and world inputs are ignored whenever the delayed vis is 0. Non-zero `icon` during blanking still gives 0x000.
- Counter widths are 10 bits. Totals ≤ 1023 are required, and parameter sets that exceed this are unsupported.

## Test plan
- **Reset then run:** hold `reset` 3 cycles, release.
  - `Colpx` = 0,1,2…
  - `horiz_sync` = `vert_sync` = 1, `video_on` = 0 and RGB = 0x000 for the first 4 cycles.
  - `video_on` = 1 first at cycle 4 (PIPE_LAT=3).
- **Line timing:**
  - `horiz_sync` low for exactly 96 cycles per line, starting 656+4 cycles after `Colpx` = 0.
  - Line period is 800 cycles.
  - `video_on` is high for 640 consecutive cycles per visible line.
- **Frame timing:**
  - `vert_sync` low for exactly 2 lines (1600 cycles), starting when delayed `Rowpx` = 490.
  - `frame_tick` pulses once per 420000 cycles, in the cycle where `Rowpx` = `Colpx` = 0.
- **Priority/colour:** with the bench model delaying coordinates by 3 cycles:
  - Drive `icon` = 10 and `world_pixel` = 11 at `Colpx` = 100, `Rowpx` = 50 → RGB = 0F0.
  - Drive `icon` = 00 with `world_pixel` = 10 → F80.
  - Drive `icon` = 00 with `world_pixel` = 00 → FFF.
- **Blanking override:** `icon` = 11 held constant → RGB = 0x000 whenever `video_on` = 0 (e.g. `Colpx` 640..799 delayed).
- **Mid-frame reset:** assert `reset` at `Rowpx` = 200, `Colpx` = 300 for 1 cycle.
  - Next cycle: counters = 0, sync outputs = 1, RGB = 0x000.
  - Normal alignment resumes after 4 cycles.
